// File: rtl/axi2mem_pkg.sv
// Shared definitions for the AXI2MEM bank arbiter: owner encodings,
// burst tracker state type and the address bit that selects a bank.
package axi2mem_pkg;

  localparam int BANK_SEL_BIT = 13;

  localparam logic [1:0] OWN_NONE = 2'b00;
  localparam logic [1:0] OWN_WR   = 2'b01;
  localparam logic [1:0] OWN_RD   = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_OWN  = 2'd2
  } burst_state_e;

endpackage

// File: rtl/axi2mem_burst_tracker.sv
// Per-engine burst tracker: request FSM, beat down-counter and done pulse.
// Grants come from the bank arbiter; release is signalled on the last beat.
import axi2mem_pkg::*;

module axi2mem_burst_tracker #(
  parameter int LEN_W = 8
) (
  input  logic             ACLK,
  input  logic             ARESETn,
  input  logic             i_req,
  input  logic             i_bank,
  input  logic [LEN_W-1:0] i_len,
  input  logic             i_beat,
  input  logic             i_grant,
  output burst_state_e     o_state,
  output logic             o_bank,
  output logic             o_gnt,
  output logic             o_done,
  output logic             o_release,
  output logic             o_err
);

  burst_state_e     r_state, w_state_next;
  logic [LEN_W-1:0] r_cnt, w_cnt_next;
  logic             r_bank, w_bank_next;
  logic             r_done;
  logic             w_release;
  logic             w_err;

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_bank  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
      r_bank  <= w_bank_next;
      r_done  <= w_release;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_bank_next  = r_bank;
    w_release    = 1'b0;
    w_err        = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (i_req) w_state_next = ST_WAIT;
      end
      ST_WAIT: begin
        // A grant on this edge beats a simultaneous request withdrawal.
        if (i_grant) begin
          w_state_next = ST_OWN;
          w_cnt_next   = i_len;
          w_bank_next  = i_bank;
        end else if (!i_req) begin
          w_state_next = ST_IDLE;
          w_err        = 1'b1;
        end
      end
      ST_OWN: begin
        if (i_beat) begin
          if (r_cnt == '0) begin
            w_state_next = ST_IDLE;
            w_release    = 1'b1;
          end else begin
            w_cnt_next = r_cnt - LEN_W'(1);
          end
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
    if (i_beat && (r_state != ST_OWN)) w_err = 1'b1;
  end

  assign o_state   = r_state;
  assign o_bank    = r_bank;
  assign o_gnt     = (r_state == ST_OWN);
  assign o_done    = r_done;
  assign o_release = w_release;
  assign o_err     = w_err;

endmodule

// File: rtl/axi2mem_bank_arbiter.sv
// Burst-level scheduler sharing the two AXI2MEM memory banks between the
// write and read engines, with per-bank round-robin on conflicts.
import axi2mem_pkg::*;

module axi2mem_bank_arbiter #(
  parameter int LEN_W    = 8,
  parameter bit WR_FIRST = 1'b1
) (
  input  logic             ACLK,
  input  logic             ARESETn,
  input  logic             wr_req,
  input  logic             wr_bank,
  input  logic [LEN_W-1:0] wr_len,
  input  logic             wr_beat,
  output logic             wr_gnt,
  output logic             wr_done,
  input  logic             rd_req,
  input  logic             rd_bank,
  input  logic [LEN_W-1:0] rd_len,
  input  logic             rd_beat,
  output logic             rd_gnt,
  output logic             rd_done,
  output logic [1:0]       bank0_owner,
  output logic [1:0]       bank1_owner,
  output logic             err
);

  burst_state_e w_wr_state, w_rd_state;
  logic         w_wr_own_bank, w_rd_own_bank;
  logic         w_wr_release, w_rd_release;
  logic         w_wr_err, w_rd_err;
  logic [1:0]   w_wr_grant_b, w_rd_grant_b;
  logic [1:0]   w_owner [2];
  logic         r_err;

  axi2mem_burst_tracker #(.LEN_W(LEN_W)) u_wr_trk (
    .ACLK      (ACLK),
    .ARESETn   (ARESETn),
    .i_req     (wr_req),
    .i_bank    (wr_bank),
    .i_len     (wr_len),
    .i_beat    (wr_beat),
    .i_grant   (|w_wr_grant_b),
    .o_state   (w_wr_state),
    .o_bank    (w_wr_own_bank),
    .o_gnt     (wr_gnt),
    .o_done    (wr_done),
    .o_release (w_wr_release),
    .o_err     (w_wr_err)
  );

  axi2mem_burst_tracker #(.LEN_W(LEN_W)) u_rd_trk (
    .ACLK      (ACLK),
    .ARESETn   (ARESETn),
    .i_req     (rd_req),
    .i_bank    (rd_bank),
    .i_len     (rd_len),
    .i_beat    (rd_beat),
    .i_grant   (|w_rd_grant_b),
    .o_state   (w_rd_state),
    .o_bank    (w_rd_own_bank),
    .o_gnt     (rd_gnt),
    .o_done    (rd_done),
    .o_release (w_rd_release),
    .o_err     (w_rd_err)
  );

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_bank
      logic       r_rr;
      logic [1:0] r_owner;
      logic       w_free, w_wr_wait, w_rd_wait;

      assign w_free    = (r_owner == OWN_NONE);
      assign w_wr_wait = (w_wr_state == ST_WAIT) && (wr_bank == 1'(gi));
      assign w_rd_wait = (w_rd_state == ST_WAIT) && (rd_bank == 1'(gi));

      // r_rr high favours the write engine when both wait on this bank.
      assign w_wr_grant_b[gi] = w_free && w_wr_wait && (!w_rd_wait || r_rr);
      assign w_rd_grant_b[gi] = w_free && w_rd_wait && (!w_wr_wait || !r_rr);

      always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
          r_rr    <= WR_FIRST;
          r_owner <= OWN_NONE;
        end else begin
          if (w_free && w_wr_wait && w_rd_wait) r_rr <= ~r_rr;
          if (w_wr_grant_b[gi])      r_owner <= OWN_WR;
          else if (w_rd_grant_b[gi]) r_owner <= OWN_RD;
          else if ((r_owner == OWN_WR && w_wr_release) ||
                   (r_owner == OWN_RD && w_rd_release))
            r_owner <= OWN_NONE;
        end
      end

      assign w_owner[gi] = r_owner;
    end
  endgenerate

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) r_err <= 1'b0;
    else          r_err <= r_err | w_wr_err | w_rd_err;
  end

  assign bank0_owner = w_owner[0];
  assign bank1_owner = w_owner[1];
  assign err         = r_err;

  a_one_owner_per_bank: assert property (@(posedge ACLK) disable iff (!ARESETn)
    !(wr_gnt && rd_gnt && (w_wr_own_bank == w_rd_own_bank)));

endmodule
